// File: rtl/axi_chan_fifo_sc.sv
// Single-clock FWFT channel FIFO with occupancy count and almost-full/empty thresholds.
// Optional sticky overflow/underflow flags are enabled by defining AXI_FIFO_ERR_EN.
module axi_chan_fifo_sc #(
  parameter int unsigned WIDTH  = 49,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned AF_LVL = DEPTH - 1,
  parameter int unsigned AE_LVL = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic                     full_o,
  output logic                     almost_full_o,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     empty_o,
  output logic                     almost_empty_o,
`ifdef AXI_FIFO_ERR_EN
  output logic                     ovf_err_o,
  output logic                     udf_err_o,
`endif
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             ren, wen;

  // Flags and count derive purely from the registered pointers; MSB is the wrap bit.
  always_comb begin
    empty_o        = (wptr_q == rptr_q);
    full_o         = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    count_o        = wptr_q - rptr_q;
    almost_full_o  = (count_o >= PW'(AF_LVL));
    almost_empty_o = (count_o <= PW'(AE_LVL));
    rdata_o        = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];
  end

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  always_comb begin
    ren    = pop_i & ~empty_o;
    wen    = push_i & (~full_o | ren);
    rptr_d = ren ? rptr_q + PW'(1) : rptr_q;
    wptr_d = wen ? wptr_q + PW'(1) : wptr_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      if (wen) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end
  end

`ifdef AXI_FIFO_ERR_EN
  logic ovf_err_q, ovf_err_d;
  logic udf_err_q, udf_err_d;

  // Sticky: a dropped push or a pop on empty latches until reset.
  always_comb begin
    ovf_err_d = ovf_err_q | (push_i & full_o & ~ren);
    udf_err_d = udf_err_q | (pop_i & empty_o);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ovf_err_q <= 1'b0;
      udf_err_q <= 1'b0;
    end else begin
      ovf_err_q <= ovf_err_d;
      udf_err_q <= udf_err_d;
    end
  end

  assign ovf_err_o = ovf_err_q;
  assign udf_err_o = udf_err_q;
`endif

endmodule

// File: tb/tb_axi_chan_fifo_sc.sv
// Self-checking bench for axi_chan_fifo_sc: directed plan steps plus random traffic
// against a queue-based occupancy model.
module tb_axi_chan_fifo_sc;

  localparam int unsigned WIDTH  = 49;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned AF_LVL = 3;
  localparam int unsigned AE_LVL = 1;
  localparam int unsigned CW     = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             push, pop;
  logic [WIDTH-1:0] wdata;
  logic             full, almost_full, empty, almost_empty;
  logic [WIDTH-1:0] rdata;
  logic [CW-1:0]    count;
`ifdef AXI_FIFO_ERR_EN
  logic             ovf_err, udf_err;
  logic             exp_ovf, exp_udf;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [WIDTH-1:0] mq[$];

  axi_chan_fifo_sc #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LVL(AF_LVL), .AE_LVL(AE_LVL)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .push_i         (push),
    .wdata_i        (wdata),
    .full_o         (full),
    .almost_full_o  (almost_full),
    .pop_i          (pop),
    .rdata_o        (rdata),
    .empty_o        (empty),
    .almost_empty_o (almost_empty),
`ifdef AXI_FIFO_ERR_EN
    .ovf_err_o      (ovf_err),
    .udf_err_o      (udf_err),
`endif
    .count_o        (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int unsigned n;
    n = mq.size();
    chk({tag, ".count"}, 64'(count), 64'(n));
    chk({tag, ".empty"}, 64'(empty), 64'(n == 0));
    chk({tag, ".full"}, 64'(full), 64'(n == DEPTH));
    chk({tag, ".afull"}, 64'(almost_full), 64'(n >= AF_LVL));
    chk({tag, ".aempty"}, 64'(almost_empty), 64'(n <= AE_LVL));
    chk({tag, ".rdata"}, 64'(rdata), (n == 0) ? 64'd0 : 64'(mq[0]));
`ifdef AXI_FIFO_ERR_EN
    chk({tag, ".ovf"}, 64'(ovf_err), 64'(exp_ovf));
    chk({tag, ".udf"}, 64'(udf_err), 64'(exp_udf));
`endif
  endtask

  // Called 1 time unit after a rising edge: drive, take the edge, update model, check.
  task automatic step(input string tag, input logic p, input logic [WIDTH-1:0] d, input logic r);
    bit do_pop, do_push;
    push  = p;
    wdata = d;
    pop   = r;
    @(posedge clk);
    #1;
    do_pop  = r && (mq.size() > 0);
    do_push = p && ((mq.size() < DEPTH) || do_pop);
`ifdef AXI_FIFO_ERR_EN
    if (p && mq.size() == DEPTH && !do_pop) exp_ovf = 1'b1;
    if (r && mq.size() == 0) exp_udf = 1'b1;
`endif
    if (do_pop) void'(mq.pop_front());
    if (do_push) mq.push_back(d);
    push = 1'b0;
    pop  = 1'b0;
    check_all(tag);
  endtask

  task automatic model_reset();
    mq.delete();
`ifdef AXI_FIFO_ERR_EN
    exp_ovf = 1'b0;
    exp_udf = 1'b0;
`endif
  endtask

  initial begin
    logic [WIDTH-1:0] d;
    rst_n = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    wdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all("reset");
    for (int i = 0; i < 3; i++) step("idle", 1'b0, '0, 1'b0);

    // Fill to full, then a dropped push.
    step("fill0", 1'b1, 49'h1_0000_0000_00AA, 1'b0);
    step("fill1", 1'b1, 49'h1_0000_0000_00BB, 1'b0);
    step("fill2", 1'b1, 49'h1_0000_0000_00CC, 1'b0);
    step("fill3", 1'b1, 49'h1_0000_0000_00DD, 1'b0);
    step("drop", 1'b1, 49'h1_0000_0000_00EE, 1'b0);
    for (int i = 0; i < 4; i++) step("drain", 1'b0, '0, 1'b1);

    // Refill, then push+pop while full.
    step("rf0", 1'b1, 49'h1_0000_0000_00AA, 1'b0);
    step("rf1", 1'b1, 49'h1_0000_0000_00BB, 1'b0);
    step("rf2", 1'b1, 49'h1_0000_0000_00CC, 1'b0);
    step("rf3", 1'b1, 49'h1_0000_0000_00DD, 1'b0);
    step("fullpp", 1'b1, 49'h0_0000_0000_0077, 1'b1);
    for (int i = 0; i < 4; i++) step("drain2", 1'b0, '0, 1'b1);

    // Wrap: hold occupancy at 2 with simultaneous push+pop.
    step("w0", 1'b1, 49'h0_1234_0000_0001, 1'b0);
    step("w1", 1'b1, 49'h0_1234_0000_0002, 1'b0);
    for (int i = 0; i < 10; i++) step("wrap", 1'b1, WIDTH'(64'h0_5A5A_0000_0100 + 64'(i)), 1'b1);
    step("wd0", 1'b0, '0, 1'b1);
    step("wd1", 1'b0, '0, 1'b1);

    // Pop while empty, and push+pop while empty.
    step("udf", 1'b0, '0, 1'b1);
    step("epp", 1'b1, 49'h0_0000_0000_0042, 1'b1);
    step("epp_pop", 1'b0, '0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      d = WIDTH'({$urandom(), $urandom()});
      step("rand", 1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset with 3 entries present, checked before any clock edge.
    while (mq.size() > 0) step("pre_rst", 1'b0, '0, 1'b1);
    step("r0", 1'b1, 49'h0_0000_0000_0011, 1'b0);
    step("r1", 1'b1, 49'h0_0000_0000_0022, 1'b0);
    step("r2", 1'b1, 49'h0_0000_0000_0033, 1'b0);
    rst_n = 1'b0;
    #2;
    model_reset();
    check_all("async_rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_all("post_rst");
    step("after_rst", 1'b1, 49'h0_0000_0000_0055, 1'b0);
    step("after_rst_pop", 1'b0, '0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/axi_chan_fifo_sc.md
Name: axi_chan_fifo_sc

Overview:
- Parametrised single-clock FIFO for buffering AXI address, data and response channels between a master/slave port and the AXI interconnect inside one clock domain.
- Generalises the fixed 49-bit, 2-entry channel FIFO: any width, any power-of-two depth, occupancy count, programmable almost-full/almost-empty thresholds, and push-while-full when a pop happens in the same cycle.
- Read data is first-word-fall-through.

Parameters:
- WIDTH, 49, payload bit width (≥1).
- DEPTH, 4, entry count; power of two, ≥2.
- AF_LVL, DEPTH-1, almost_full asserts when count ≥ AF_LVL.
- AE_LVL, 1, almost_empty asserts when count ≤ AE_LVL.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- push  in  1  write request.
- wdata  in  WIDTH  write payload.
- full  out  1  count == DEPTH.
- almost_full  out  1  count ≥ AF_LVL.
- pop  in  1  read request; consumes the head entry.
- rdata  out  WIDTH  head entry; 0 when empty.
- empty  out  1  count == 0.
- almost_empty  out  1  count ≤ AE_LVL.
- count  out  $clog2(DEPTH)+1  current occupancy.

Behaviour:
- Pointers: wptr and rptr are $clog2(DEPTH)+1 bits wide. The LSBs index memory; the MSB is the wrap bit.
- empty = (wptr == rptr).
- full = MSBs differ and index bits are equal.
- count = wptr - rptr, computed modulo 2^($clog2(DEPTH)+1).
- Reset (rst=0, asynchronous assert, synchronous deassert by upstream):
  - wptr=0, rptr=0, all memory entries=0.
  - Outputs: full=0, almost_full=(AF_LVL==0), empty=1, almost_empty=1, count=0, rdata=0.
- Pop:
  - ren = pop & !empty.
  - On ren: rptr += 1.
  - Pop while empty is ignored; state is unchanged.
- Push:
  - wen = push & (!full | ren).
  - On wen: mem[wptr index] <= wdata; wptr += 1.
  - Push while full without a pop is dropped; wdata is lost and no state changes.
- Simultaneous push+pop:
  - Non-empty: both proceed; count is unchanged.
  - Full: the pop frees the head slot and the push writes into it in the same edge; count stays DEPTH, full stays 1.
  - Empty: the pop is ignored, the push proceeds, count becomes 1. Push data is not bypassed to rdata in the same cycle.
- Latency:
  - A written word appears on rdata the cycle after the push edge; empty drops in the same cycle.
  - rdata is combinational from mem[rptr index], gated to 0 when empty.
- Flags: all flags and count are combinational from the registered pointers, so they update one edge after the causing push or pop.
- Wrap-around: pointers roll over naturally. Full and empty remain correct across any number of wraps.
- Reset mid-operation: all contents are discarded immediately; the block is empty after reset.

Optional Feature:
- Macro: AXI_FIFO_ERR_EN.
- When defined, adds two output ports, ovf_err and udf_err, each 1 bit.
- Both are sticky, set on the clock edge and cleared only by reset.
  - ovf_err sets when push=1, full=1 and ren=0 (a write was dropped).
  - udf_err sets when pop=1 and empty=1.
- Both reset to 0.
- When undefined, neither port nor any of its logic exists; the dropped-push and ignored-pop behaviour above is unchanged.

Test Plan (WIDTH=49, DEPTH=4, AF_LVL=3, AE_LVL=1):
- Reset, then idle 3 cycles → empty=1, almost_empty=1, full=0, almost_full=0, count=0, rdata=0.
- Push 0x1_0000_0000_00AA..0xDD on 4 consecutive cycles:
  - count goes 1,2,3,4.
  - almost_full=1 at count 3.
  - full=1 at count 4.
  - rdata=0x..AA from the cycle after the first push.
- Full, push 0xEE without pop → dropped; count=4, ovf_err=1 (with AXI_FIFO_ERR_EN).
  - Then 4 pops return AA,BB,CC,DD in order, and empty=1 afterwards.
- Full, push 0x77 with pop in the same cycle → count stays 4, full=1.
  - Subsequent pops return BB,CC,DD,77.
- Wrap test: 10 iterations of push+pop with count held at 2 → data order preserved, count=2 throughout, pointers wrap at least twice.
- Pop while empty → no change, count=0, udf_err=1 (with macro).
  - Assert rst=0 with 3 entries present → count=0, empty=1, rdata=0 immediately, without waiting for a clock edge.
